// File: rtl/majority_frame_collector_pkg.sv
// ============================================================================
// Module      : majority_frame_collector_pkg
// Description : Shared constants and FILL/HOLD state encoding for the
//               serial-to-parallel frame collector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package majority_frame_collector_pkg;

    localparam int unsigned C_SIZE_DEFAULT = 9;
    localparam int unsigned C_CNT_W        = 4;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/majority_frame_collector_if.sv
// ============================================================================
// Module      : majority_frame_collector_if
// Description : Serial-bit input handshake and frame output handshake bundle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface majority_frame_collector_if
    import majority_frame_collector_pkg::*;
#(
    parameter int unsigned SIZE = C_SIZE_DEFAULT
);

    logic               bit_in;
    logic               bit_valid;
    logic               bit_ready;
    logic               abort;
    logic [SIZE-1:0]    Data;
    logic               data_valid;
    logic               data_ready;
    logic [C_CNT_W-1:0] fill_count;

    modport master (
        output bit_in, bit_valid, abort, data_ready,
        input  bit_ready, Data, data_valid, fill_count
    );

    modport slave (
        input  bit_in, bit_valid, abort, data_ready,
        output bit_ready, Data, data_valid, fill_count
    );

endinterface

`default_nettype wire

// File: rtl/majority_frame_collector.sv
// ============================================================================
// Module      : majority_frame_collector
// Description : Collects SIZE serial bits (LSB first) into a frame and holds it
//               for the downstream majority voter until consumed or aborted.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module majority_frame_collector
    import majority_frame_collector_pkg::*;
#(
    parameter int unsigned SIZE = C_SIZE_DEFAULT
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    majority_frame_collector_if.slave bus
);

    if (SIZE < 1 || SIZE > 15) begin : g_size_check
        $error("majority_frame_collector: SIZE must be within 1..15");
    end

    state_t             state_q, state_d;
    logic [SIZE-1:0]    data_q, data_d;
    logic [C_CNT_W-1:0] fill_count_q, fill_count_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_FILL;
            data_q       <= '0;
            fill_count_q <= '0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            fill_count_q <= fill_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        fill_count_d = fill_count_q;

        if (bus.abort) begin
            state_d      = ST_FILL;
            data_d       = '0;
            fill_count_d = '0;
        end else begin
            case (state_q)
                ST_FILL: begin
                    if (bus.bit_valid) begin
                        // fill_count doubles as the write index of the next bit
                        for (int k = 0; k < SIZE; k++) begin
                            if (fill_count_q == C_CNT_W'(k)) begin
                                data_d[k] = bus.bit_in;
                            end
                        end
                        fill_count_d = fill_count_q + C_CNT_W'(1);
                        if (fill_count_q == C_CNT_W'(SIZE - 1)) begin
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.data_ready) begin
                        state_d      = ST_FILL;
                        data_d       = '0;
                        fill_count_d = '0;
                    end
                end
                default: begin
                    state_d      = ST_FILL;
                    data_d       = '0;
                    fill_count_d = '0;
                end
            endcase
        end
    end

    assign bus.bit_ready  = (state_q == ST_FILL);
    assign bus.data_valid = (state_q == ST_HOLD);
    assign bus.Data       = data_q;
    assign bus.fill_count = fill_count_q;

endmodule

`default_nettype wire

// File: doc/majority_frame_collector.md
MAJORITY_FRAME_COLLECTOR -- requirements
Module: majority_frame_collector

Interface
REQ-001 The block SHALL have parameter SIZE, default 9, giving the frame width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising edge active.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port bit_in, input, 1 bit: serial sample.
REQ-005 The block SHALL have port bit_valid, input, 1 bit: bit_in is valid this cycle.
REQ-006 The block SHALL have port bit_ready, output, 1 bit: block accepts a bit this cycle.
REQ-007 The block SHALL have port abort, input, 1 bit: discards the partial or held frame.
REQ-008 The block SHALL have port Data, output, SIZE bits: assembled frame for the downstream majority voter.
REQ-009 The block SHALL have port data_valid, output, 1 bit: Data holds a complete frame.
REQ-010 The block SHALL have port data_ready, input, 1 bit: downstream consumes the frame.
REQ-011 The block SHALL have port fill_count, output, 4 bits: bits accepted into the current frame, 0..SIZE.

Function
REQ-012 The block SHALL have two states: FILL (accepting bits) and HOLD (presenting a frame).
REQ-013 In FILL, bit_ready SHALL be 1 and data_valid 0; in HOLD, bit_ready SHALL be 0 and data_valid 1.
REQ-014 A bit SHALL be accepted on a rising edge with bit_valid=1 and bit_ready=1.
REQ-015 The k-th accepted bit of a frame (k=0..SIZE-1) SHALL be written to Data[k], first bit at the LSB.
REQ-016 Each accepted bit SHALL increment fill_count by 1; bits not yet written SHALL read 0 in Data.
REQ-017 On acceptance of bit SIZE-1, the state SHALL become HOLD on that edge, with fill_count=SIZE and data_valid=1 in the next cycle (1-cycle latency).
REQ-018 In HOLD, Data and fill_count SHALL be stable until the frame is consumed.
REQ-019 The frame SHALL be consumed on an edge with data_valid=1 and data_ready=1; on that edge, Data SHALL clear to 0, fill_count to 0, and the state SHALL become FILL.
REQ-020 A bit SHALL NOT be accepted in the consume cycle, because bit_ready=0 in HOLD; bit_valid in HOLD SHALL be ignored.
REQ-021 abort=1 on an edge SHALL clear Data, fill_count and data_valid and force FILL, taking priority over acceptance and consumption in the same cycle.
REQ-022 data_ready asserted in FILL SHALL have no effect.
REQ-023 fill_count SHALL never exceed SIZE; SIZE SHALL be limited to 1..15.

Reset
REQ-024 While rst_n=0 at a rising edge, the block SHALL enter FILL with Data=0, fill_count=0, data_valid=0 and bit_ready=1 after that edge.
REQ-025 Reset SHALL take priority over abort, acceptance and consumption, and SHALL discard a partial or held frame mid-operation.
REQ-026 No output SHALL change asynchronously to clk.

Structure
REQ-027 A shared package SHALL hold the SIZE default, the fill_count width (4) and the FILL/HOLD state encoding.
REQ-028 The block SHALL be a single module with no sub-module; the shift/index logic and counter SHALL be inline.
REQ-029 Data SHALL connect directly to the downstream combinational majority voter's Data input.

Verification
REQ-030 Scenario "basic frame": SIZE=9, bits 1,0,1,1,0,0,1,1,1 on consecutive cycles with bit_valid=1 -> data_valid=1 the cycle after the 9th bit, Data=9'h1CD, fill_count=9.
REQ-031 Scenario "backpressure": hold data_ready=0 for 5 cycles after the frame completes while bit_valid=1 -> bit_ready=0, Data stays 9'h1CD; then data_ready=1 -> next cycle Data=0, fill_count=0, bit_ready=1.
REQ-032 Scenario "gapped input": 9 bits with bit_valid toggling 1/0 -> fill_count advances only on valid cycles; frame completes after the 9th valid bit.
REQ-033 Scenario "abort": abort after 4 bits -> next cycle fill_count=0, Data=0; then a fresh 9-bit all-ones frame -> Data=9'h1FF.
REQ-034 Scenario "reset mid-frame": rst_n=0 for 1 cycle while in HOLD with data_ready=1 and abort=0 -> data_valid=0, fill_count=0, Data=0, bit_ready=1.
REQ-035 Scenario "abort and consume together": in HOLD, abort=1 and data_ready=1 in the same cycle -> FILL, Data=0, and exactly one consume seen by the scoreboard.
